// File: rtl/rvvi_tx_scheduler_if.sv
// AXI-stream bundle shared by the scheduler's two frame sources and its MAC-facing output.
// The master drives data/valid/user; the slave returns tready.
interface rvvi_tx_scheduler_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;
    logic                    tuser;

    modport master (output tdata, tkeep, tlast, tvalid, tuser, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/rvvi_tx_scheduler.sv
// rvvi_tx_scheduler: frame-atomic arbiter sharing the MAC transmit stream between trace (s0) and control (s1).
// Define RVVI_TX_WATCHDOG_EN to build the mid-frame stall watchdog (ABORT/DRAIN states, AbortCount).
module rvvi_tx_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_SKIP   = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_aresetn,
    rvvi_tx_scheduler_if.slave   s0,
    rvvi_tx_scheduler_if.slave   s1,
    rvvi_tx_scheduler_if.master  mt,
    input  logic [31:0]          InterPacketDelay,
    input  logic                 Enable,
    output logic                 Busy,
    output logic [CNT_WIDTH-1:0] FrameCount0,
    output logic [CNT_WIDTH-1:0] FrameCount1,
    output logic [7:0]           AbortCount
);
    localparam int KW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, ABORT, DRAIN, GAP} state_e;

    state_e               state_q, state_d;
    logic [2:0]           skip_q, skip_d;
    logic [31:0]          gap_q, gap_d;
    logic [CNT_WIDTH-1:0] fc0_q, fc0_d, fc1_q, fc1_d;
    logic                 src1, cur_valid, cur_last, beat, grant1_ok;

`ifdef RVVI_TX_WATCHDOG_EN
    localparam int IW = $clog2(TIMEOUT) + 1;
    logic [IW-1:0] idle_q, idle_d;
    logic          src_q, src_d;
    logic [7:0]    abort_q, abort_d;

    // ABORT/DRAIN remember which source owned the interrupted frame
    assign src1       = (state_q == GRANT1) || (((state_q == ABORT) || (state_q == DRAIN)) && src_q);
    assign AbortCount = abort_q;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
    assign src1       = (state_q == GRANT1);
    assign AbortCount = '0;
`endif

    assign cur_valid = src1 ? s1.tvalid : s0.tvalid;
    assign cur_last  = src1 ? s1.tlast : s0.tlast;
    assign beat      = cur_valid && mt.tready;
    // Source 1 wins unless trace has been passed over MAX_SKIP times in a row
    assign grant1_ok = s1.tvalid && ((int'(skip_q) < MAX_SKIP) || !s0.tvalid);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        gap_d   = gap_q;
        fc0_d   = fc0_q;
        fc1_d   = fc1_q;
`ifdef RVVI_TX_WATCHDOG_EN
        idle_d  = idle_q;
        src_d   = src_q;
        abort_d = abort_q;
`endif
        mt.tvalid = 1'b0;
        mt.tdata  = '0;
        mt.tkeep  = '0;
        mt.tlast  = 1'b0;
        mt.tuser  = 1'b0;
        s0.tready = 1'b0;
        s1.tready = 1'b0;

        case (state_q)
            IDLE: begin
                if (Enable && grant1_ok) begin
                    state_d = GRANT1;
                    if (s0.tvalid && (skip_q != 3'd7)) skip_d = skip_q + 3'd1;
`ifdef RVVI_TX_WATCHDOG_EN
                    idle_d = '0;
                    src_d  = 1'b1;
`endif
                end else if (Enable && s0.tvalid) begin
                    state_d = GRANT0;
                    skip_d  = '0;
`ifdef RVVI_TX_WATCHDOG_EN
                    idle_d = '0;
                    src_d  = 1'b0;
`endif
                end
            end
            GRANT0, GRANT1: begin
                mt.tvalid = cur_valid;
                mt.tdata  = src1 ? s1.tdata : s0.tdata;
                mt.tkeep  = src1 ? s1.tkeep : s0.tkeep;
                mt.tlast  = cur_last;
                s0.tready = !src1 && mt.tready;
                s1.tready = src1 && mt.tready;
                if (beat) begin
`ifdef RVVI_TX_WATCHDOG_EN
                    idle_d = '0;
`endif
                    if (cur_last) begin
                        if (src1) fc1_d = fc1_q + CNT_WIDTH'(1);
                        else      fc0_d = fc0_q + CNT_WIDTH'(1);
                        gap_d   = InterPacketDelay;
                        state_d = (InterPacketDelay == 32'd0) ? IDLE : GAP;
                    end
                end
`ifdef RVVI_TX_WATCHDOG_EN
                // Abort once this idle cycle would bring the count to TIMEOUT-1
                else if (!cur_valid) begin
                    if (idle_q == IW'(TIMEOUT - 2)) state_d = ABORT;
                    else                            idle_d  = idle_q + IW'(1);
                end
`endif
            end
`ifdef RVVI_TX_WATCHDOG_EN
            ABORT: begin
                mt.tvalid = 1'b1;
                mt.tlast  = 1'b1;
                mt.tuser  = 1'b1;
                mt.tkeep  = KW'(1);
                if (mt.tready) begin
                    if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                s0.tready = !src1;
                s1.tready = src1;
                if (cur_valid && cur_last) begin
                    gap_d   = InterPacketDelay;
                    state_d = (InterPacketDelay == 32'd0) ? IDLE : GAP;
                end
            end
`endif
            GAP: begin
                if (gap_q != 32'd0) gap_d = gap_q - 32'd1;
                if (gap_q <= 32'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q <= IDLE;
            skip_q  <= '0;
            gap_q   <= '0;
            fc0_q   <= '0;
            fc1_q   <= '0;
`ifdef RVVI_TX_WATCHDOG_EN
            idle_q  <= '0;
            src_q   <= 1'b0;
            abort_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            gap_q   <= gap_d;
            fc0_q   <= fc0_d;
            fc1_q   <= fc1_d;
`ifdef RVVI_TX_WATCHDOG_EN
            idle_q  <= idle_d;
            src_q   <= src_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign Busy        = (state_q != IDLE);
    assign FrameCount0 = fc0_q;
    assign FrameCount1 = fc1_q;
endmodule

// File: tb/tb_rvvi_tx_scheduler.sv
// Self-checking bench for rvvi_tx_scheduler: queue-driven sources, MT scoreboard, counter/timing checks.
// The watchdog scenario runs only when RVVI_TX_WATCHDOG_EN is defined.
module tb_rvvi_tx_scheduler;
    localparam int DW = 32;

    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    typedef struct packed { logic [31:0] data; logic last; logic user; logic [3:0] keep; } exp_t;

    logic        clk, rst_n, en, busy;
    logic [31:0] ipd;
    logic [15:0] fc0, fc1;
    logic [7:0]  abort_cnt;

    rvvi_tx_scheduler_if #(.DATA_WIDTH(DW)) s0_if ();
    rvvi_tx_scheduler_if #(.DATA_WIDTH(DW)) s1_if ();
    rvvi_tx_scheduler_if #(.DATA_WIDTH(DW)) mt_if ();

    rvvi_tx_scheduler #(.DATA_WIDTH(DW), .MAX_SKIP(4), .TIMEOUT(8), .CNT_WIDTH(16)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .s0(s0_if), .s1(s1_if), .mt(mt_if),
        .InterPacketDelay(ipd), .Enable(en), .Busy(busy),
        .FrameCount0(fc0), .FrameCount1(fc1), .AbortCount(abort_cnt)
    );

    beat_t       q0[$], q1[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          beat_cyc[$];
    int          nbeats = 0, cyc = 0, n_chk = 0, n_pass = 0;
    bit          took0 = 0, took1 = 0, stall_pend = 0;
    logic [31:0] stall_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        if (obs !== want) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int src, input logic [31:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.last = last;
        if (src == 1) q1.push_back(b);
        else          q0.push_back(b);
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic last, input logic user, input logic [3:0] keep);
        exp_t e;
        e.data = d; e.last = last; e.user = user; e.keep = keep;
        exp_q.push_back(e);
    endtask

    task automatic wait_beats(input int target, input string tag);
        for (int i = 0; i < 300 && nbeats < target; i++) tick(1);
        chk({tag, "_beats"}, nbeats, target);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: reached cycle %0d without finishing", cyc);
        $fatal(1);
    end

    // Source models: present queue heads, pop after an observed handshake
    initial begin
        s0_if.tvalid = 0; s0_if.tdata = '0; s0_if.tkeep = 4'hF; s0_if.tlast = 0; s0_if.tuser = 0;
        s1_if.tvalid = 0; s1_if.tdata = '0; s1_if.tkeep = 4'hF; s1_if.tlast = 0; s1_if.tuser = 0;
        forever begin
            @(posedge clk);
            #1;
            if (took0 && q0.size() > 0) void'(q0.pop_front());
            if (took1 && q1.size() > 0) void'(q1.pop_front());
            took0 = 0;
            took1 = 0;
            s0_if.tvalid = (q0.size() != 0);
            if (q0.size() != 0) begin s0_if.tdata = q0[0].data; s0_if.tlast = q0[0].last; end
            else begin s0_if.tdata = '0; s0_if.tlast = 0; end
            s1_if.tvalid = (q1.size() != 0);
            if (q1.size() != 0) begin s1_if.tdata = q1[0].data; s1_if.tlast = q1[0].last; end
            else begin s1_if.tdata = '0; s1_if.tlast = 0; end
        end
    end

    // MT monitor and scoreboard, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        cyc++;
        took0 = s0_if.tvalid && s0_if.tready;
        took1 = s1_if.tvalid && s1_if.tready;
        if (rst_n && stall_pend) chk("stall_hold_data", mt_if.tdata, stall_data);
        stall_pend = rst_n && mt_if.tvalid && !mt_if.tready;
        stall_data = mt_if.tdata;
        if (rst_n && mt_if.tvalid && mt_if.tready) begin
            nbeats++;
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("sb_extra_beat", exp_q.size(), 1);
            else begin
                mon_e = exp_q.pop_front();
                chk("sb_data", mt_if.tdata, mon_e.data);
                chk("sb_last", mt_if.tlast, mon_e.last);
                chk("sb_user", mt_if.tuser, mon_e.user);
                chk("sb_keep", mt_if.tkeep, mon_e.keep);
            end
        end
    end

    initial begin
        int base, f0b, f1b, t0;
        bit found;
        rst_n = 0; en = 0; ipd = 0; mt_if.tready = 1;
        tick(3);
        chk("rst_mtvalid", mt_if.tvalid, 0);
        chk("rst_mtdata", mt_if.tdata, 0);
        chk("rst_mtkeep", mt_if.tkeep, 0);
        chk("rst_mtlast", mt_if.tlast, 0);
        chk("rst_mtuser", mt_if.tuser, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s0ready", s0_if.tready, 0);
        chk("rst_s1ready", s1_if.tready, 0);
        chk("rst_fc0", fc0, 0);
        chk("rst_fc1", fc1, 0);
        chk("rst_abort", abort_cnt, 0);
        rst_n = 1;
        tick(2);

        // Enable gating: both valid, nothing granted until Enable rises
        push(1, 32'h1100_0001, 1); push(0, 32'h0000_0A01, 1);
        expect_beat(32'h1100_0001, 1, 0, 4'hF); expect_beat(32'h0000_0A01, 1, 0, 4'hF);
        tick(5);
        chk("en_off_busy", busy, 0);
        chk("en_off_beats", nbeats, 0);
        en = 1;
        @(negedge clk);
        chk("en_same_cycle_busy", busy, 0);
        @(negedge clk);
        chk("en_grant_busy", busy, 1);
        chk("en_grant_s1ready", s1_if.tready, 1);
        chk("en_grant_s0ready", s0_if.tready, 0);
        chk("en_grant_data", mt_if.tdata, 32'h1100_0001);
        tick(1);
        wait_beats(2, "en");
        tick(2);
        chk("en_fc1", fc1, 1);
        chk("en_fc0", fc0, 1);

        // Single source 0, 3-beat frames with a 2-cycle gap
        ipd = 2; base = nbeats;
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < 3; b++) begin
                push(0, 32'hA000_0000 + 32'(f * 16 + b), b == 2);
                expect_beat(32'hA000_0000 + 32'(f * 16 + b), b == 2, 0, 4'hF);
            end
        wait_beats(base + 3, "gap_f1");
        tick(1);
        chk("gap_fc0_after_f1", fc0, 2);
        wait_beats(base + 4, "gap_f2b1");
        chk("gap_spacing", beat_cyc[base + 3] - beat_cyc[base + 2], 4);
        wait_beats(base + 6, "gap_f2");
        tick(5);
        chk("gap_fc0_after_f2", fc0, 3);

        // Backpressure on a 2-beat source-1 frame: ready 1,0,0,1
        ipd = 0; base = nbeats; f1b = fc1; found = 0;
        push(1, 32'h2200_0000, 0); push(1, 32'h2200_0001, 1);
        expect_beat(32'h2200_0000, 0, 0, 4'hF); expect_beat(32'h2200_0001, 1, 0, 4'hF);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (busy) found = 1;
        end
        chk("bp_granted", found, 1);
        chk("bp_s1ready_c0", s1_if.tready, mt_if.tready);
        chk("bp_data_c0", mt_if.tdata, 32'h2200_0000);
        for (int c = 1; c < 4; c++) begin
            @(posedge clk);
            #2;
            mt_if.tready = (c == 3);
            @(negedge clk);
            chk("bp_s1ready", s1_if.tready, mt_if.tready);
            chk("bp_data_held", mt_if.tdata, 32'h2200_0001);
        end
        tick(3);
        chk("bp_transfers", nbeats - base, 2);
        chk("bp_fc1", fc1 - f1b, 1);

        // Starvation guard: both sources continuously valid with 1-beat frames
        base = nbeats; f0b = fc0; f1b = fc1;
        for (int i = 0; i < 8; i++) push(1, 32'h1000_0000 + 32'(i), 1);
        for (int i = 0; i < 2; i++) push(0, 32'h0000_00B0 + 32'(i), 1);
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++) expect_beat(32'h1000_0000 + 32'(g * 4 + i), 1, 0, 4'hF);
            expect_beat(32'h0000_00B0 + 32'(g), 1, 0, 4'hF);
        end
        wait_beats(base + 10, "starve");
        tick(3);
        chk("starve_fc1", fc1 - f1b, 8);
        chk("starve_fc0", fc0 - f0b, 2);

`ifdef RVVI_TX_WATCHDOG_EN
        // Watchdog: source 0 stalls mid-frame, abort beat then the rest is drained
        base = nbeats; f0b = fc0;
        push(0, 32'h3300_0000, 0);
        expect_beat(32'h3300_0000, 0, 0, 4'hF);
        wait_beats(base + 1, "wd_b1");
        t0 = beat_cyc[base];
        expect_beat(32'h0, 1, 1, 4'h1);
        wait_beats(base + 2, "wd_abort");
        chk("wd_abort_delay", beat_cyc[base + 1] - t0, 8);
        tick(2);
        push(0, 32'h3300_0001, 0); push(0, 32'h3300_0002, 1);
        for (int i = 0; i < 50 && q0.size() != 0; i++) tick(1);
        chk("wd_drained", q0.size(), 0);
        tick(3);
        chk("wd_abortcnt", abort_cnt, 1);
        chk("wd_fc0", fc0 - f0b, 0);
        chk("wd_no_mt_beats", nbeats - base, 2);
        chk("wd_idle", busy, 0);
`else
        chk("abort_tied", abort_cnt, 0);
        t0 = 0;
`endif

        // Mid-frame reset during beat 2 of a 4-beat frame
        base = nbeats;
        for (int b = 0; b < 4; b++) begin
            push(0, 32'h4400_0000 + 32'(b), b == 3);
            expect_beat(32'h4400_0000 + 32'(b), b == 3, 0, 4'hF);
        end
        wait_beats(base + 1, "mr_b1");
        chk("mr_beat2_on_bus", mt_if.tdata, 32'h4400_0001);
        rst_n = 0;
        #1;
        chk("mr_mtvalid", mt_if.tvalid, 0);
        chk("mr_mtdata", mt_if.tdata, 0);
        chk("mr_busy", busy, 0);
        chk("mr_s0ready", s0_if.tready, 0);
        chk("mr_fc0", fc0, 0);
        chk("mr_fc1", fc1, 0);
        chk("mr_abort", abort_cnt, 0);
        q0.delete();
        exp_q.delete();
        s0_if.tvalid = 0;
        s0_if.tlast = 0;
        tick(2);
        rst_n = 1;
        tick(1);
        base = nbeats;
        push(0, 32'h4500_0000, 0); push(0, 32'h4500_0001, 1);
        expect_beat(32'h4500_0000, 0, 0, 4'hF); expect_beat(32'h4500_0001, 1, 0, 4'hF);
        wait_beats(base + 2, "mr_after");
        tick(2);
        chk("mr_after_fc0", fc0, 1);
        chk("mr_after_fc1", fc1, 0);

        tick(3);
        chk("sb_leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
